// File: rtl/sram_req_arbiter.sv
// Two-port SRAM-like request arbiter: shares one master port between inst and data, routing responses in issue order via a tag FIFO.
// Optional macro ARB_RR_EN: round-robin unlocked grant instead of fixed data-over-inst priority.
module sram_req_arbiter #(
  parameter int OUTST_DEPTH = 4,
  parameter int PTR_W       = 2
) (
  input  logic             clk,
  input  logic             resetn,

  input  logic             inst_req,
  input  logic             inst_wr,
  input  logic [1:0]       inst_size,
  input  logic [3:0]       inst_wstrb,
  input  logic [31:0]      inst_addr,
  input  logic [31:0]      inst_wdata,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [31:0]      inst_rdata,

  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [3:0]       data_wstrb,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [31:0]      data_rdata,

  output logic             m_req,
  output logic             m_wr,
  output logic [1:0]       m_size,
  output logic [3:0]       m_wstrb,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  input  logic             m_addr_ok,
  input  logic             m_data_ok,
  input  logic [31:0]      m_rdata,

  output logic [PTR_W:0]   outst_cnt,
  output logic             resp_err
);

  localparam logic             PORT_INST = 1'b0;
  localparam logic             PORT_DATA = 1'b1;
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(OUTST_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  lock_state_t      state_reg, state_next;
  logic             lock_id_reg, lock_id_next;
  logic [PTR_W-1:0] wptr_reg, rptr_reg;
  logic [PTR_W:0]   cnt_reg, cnt_next;
  logic             fifo_reg [OUTST_DEPTH];
  logic             resp_err_reg;

  logic sel;
  logic unlocked_sel;
  logic fifo_empty;
  logic fifo_full;
  logic head;
  logic push;
  logic pop;

`ifdef ARB_RR_EN
  logic rr_last_reg;

  // Under contention the port that lost the previous handshake goes next.
  always_comb begin
    unlocked_sel = PORT_INST;
    if (inst_req && data_req)
      unlocked_sel = ~rr_last_reg;
    else if (data_req)
      unlocked_sel = PORT_DATA;
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      rr_last_reg <= PORT_INST;
    else if (push)
      rr_last_reg <= sel;
  end
`else
  always_comb begin
    unlocked_sel = data_req ? PORT_DATA : PORT_INST;
  end
`endif

  assign fifo_empty = (cnt_reg == '0);
  assign fifo_full  = (cnt_reg == CNT_FULL);
  assign sel        = (state_reg == ST_LOCKED) ? lock_id_reg : unlocked_sel;

  // Full is judged on the registered count only, so m_data_ok never reaches m_req.
  assign m_req = (inst_req | data_req) & ~fifo_full & resetn;
  assign push  = m_req & m_addr_ok;

  always_comb begin
    m_wr    = inst_wr;
    m_size  = inst_size;
    m_wstrb = inst_wstrb;
    m_addr  = inst_addr;
    m_wdata = inst_wdata;
    if (sel == PORT_DATA) begin
      m_wr    = data_wr;
      m_size  = data_size;
      m_wstrb = data_wstrb;
      m_addr  = data_addr;
      m_wdata = data_wdata;
    end
  end

  assign inst_addr_ok = push & (sel == PORT_INST);
  assign data_addr_ok = push & (sel == PORT_DATA);

  assign head         = fifo_reg[rptr_reg];
  assign pop          = m_data_ok & ~fifo_empty & resetn;
  assign inst_data_ok = pop & (head == PORT_INST);
  assign data_data_ok = pop & (head == PORT_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  // Grant lock keeps the master request stable until it is accepted.
  always_comb begin
    state_next   = state_reg;
    lock_id_next = lock_id_reg;
    if (push) begin
      state_next = ST_FREE;
    end else if (m_req) begin
      state_next   = ST_LOCKED;
      lock_id_next = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= ST_FREE;
      lock_id_reg <= PORT_INST;
    end else begin
      state_reg   <= state_next;
      lock_id_reg <= lock_id_next;
    end
  end

  for (genvar gi = 0; gi < OUTST_DEPTH; gi++) begin : g_fifo
    always_ff @(posedge clk) begin
      if (!resetn)
        fifo_reg[gi] <= PORT_INST;
      else if (push && (wptr_reg == PTR_W'(gi)))
        fifo_reg[gi] <= sel;
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    case ({push, pop})
      2'b10:   cnt_next = cnt_reg + CNT_ONE;
      2'b01:   cnt_next = cnt_reg - CNT_ONE;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      cnt_reg      <= '0;
      resp_err_reg <= 1'b0;
    end else begin
      if (push)
        wptr_reg <= wptr_reg + PTR_ONE;
      if (pop)
        rptr_reg <= rptr_reg + PTR_ONE;
      cnt_reg <= cnt_next;
      // A response with nothing outstanding is dropped and latched as an error.
      if (m_data_ok && fifo_empty)
        resp_err_reg <= 1'b1;
    end
  end

  assign outst_cnt = cnt_reg;
  assign resp_err  = resp_err_reg;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: grant, lock, in-order routing, full/wrap, error and optional round-robin.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic [2:0]  outst_cnt;
  logic        resp_err;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  sram_req_arbiter #(.OUTST_DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .outst_cnt(outst_cnt), .resp_err(resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted request from a single port; the other port is idle.
  task automatic issue(input bit is_data, input logic [31:0] addr);
    if (is_data) begin
      data_req = 1'b1; data_addr = addr; data_wdata = ~addr;
    end else begin
      inst_req = 1'b1; inst_addr = addr;
    end
    m_addr_ok = 1'b1;
    #1;
    chk("data_addr_ok", data_addr_ok, is_data);
    chk("inst_addr_ok", inst_addr_ok, !is_data);
    chk("m_addr", m_addr, addr);
    chk("m_wr", m_wr, is_data);
    chk("m_size", m_size, is_data ? 32'd1 : 32'd2);
    chk("m_wstrb", m_wstrb, is_data ? 32'h3 : 32'hf);
    chk("m_wdata", m_wdata, is_data ? ~addr : 32'h1111_1111);
    tick();
    inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0;
    exp_q.push_back(is_data);
  endtask

  task automatic respond(input logic [31:0] rd);
    bit d;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL respond_queue observed empty expected entry");
      return;
    end
    d = exp_q.pop_front();
    m_data_ok = 1'b1; m_rdata = rd;
    #1;
    chk("data_data_ok", data_data_ok, d);
    chk("inst_data_ok", inst_data_ok, !d);
    chk("rdata", d ? data_rdata : inst_rdata, rd);
    tick();
    m_data_ok = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hf;
    inst_addr = 32'h1FC0_0000; inst_wdata = 32'h1111_1111;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_wstrb = 4'h3;
    data_addr = 32'h0; data_wdata = 32'h0;
    m_addr_ok = 1'b1; m_data_ok = 1'b0; m_rdata = 32'h0;

    // Reset with both ports requesting
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_req", m_req, 0);
    chk("rst_cnt", outst_cnt, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_daok", data_addr_ok, 0);
    chk("rst_iaok", inst_addr_ok, 0);
    resetn = 1'b1; inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0;
    tick();

    // Fixed priority: data wins, then inst
    inst_req = 1'b1; data_req = 1'b1; data_addr = 32'h1C00_0100; m_addr_ok = 1'b1;
    #1;
    chk("prio_m_addr", m_addr, 32'h1C00_0100);
    chk("prio_daok", data_addr_ok, 1);
    chk("prio_iaok", inst_addr_ok, 0);
    tick();
    data_req = 1'b0;
    #1;
    chk("prio2_m_addr", m_addr, 32'h1FC0_0000);
    chk("prio2_iaok", inst_addr_ok, 1);
    chk("prio2_daok", data_addr_ok, 0);
    tick();
    inst_req = 1'b0; m_addr_ok = 1'b0;
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    #1;
    chk("prio_cnt", outst_cnt, 2);
    respond(32'h0000_0011);
    respond(32'h0000_0022);
    chk("prio_cnt_end", outst_cnt, 0);

    // Lock on data while inst arrives
    data_req = 1'b1; data_addr = 32'h0000_0100;
    #1;
    chk("lock_m_req", m_req, 1);
    chk("lock_c1", m_addr, 32'h0000_0100);
    tick();
    inst_req = 1'b1; inst_addr = 32'h0000_0200;
    #1;
    chk("lock_c2", m_addr, 32'h0000_0100);
    chk("lock_c2_iaok", inst_addr_ok, 0);
    tick();
    #1;
    chk("lock_c3", m_addr, 32'h0000_0100);
    tick();
    m_addr_ok = 1'b1;
    #1;
    chk("lock_c4_daok", data_addr_ok, 1);
    chk("lock_c4_addr", m_addr, 32'h0000_0100);
    tick();
    data_req = 1'b0;
    #1;
    chk("lock_c5_iaok", inst_addr_ok, 1);
    chk("lock_c5_addr", m_addr, 32'h0000_0200);
    tick();
    inst_req = 1'b0; m_addr_ok = 1'b0;
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);

    // Lock on inst holds against higher-priority data
    inst_req = 1'b1; inst_addr = 32'h0000_0300;
    #1;
    chk("ilock_c1", m_addr, 32'h0000_0300);
    tick();
    data_req = 1'b1; data_addr = 32'h0000_0400; data_wdata = 32'h0;
    #1;
    chk("ilock_c2", m_addr, 32'h0000_0300);
    chk("ilock_c2_m_wr", m_wr, 0);
    tick();
    m_addr_ok = 1'b1;
    #1;
    chk("ilock_c3_iaok", inst_addr_ok, 1);
    chk("ilock_c3_daok", data_addr_ok, 0);
    chk("ilock_c3_addr", m_addr, 32'h0000_0300);
    tick();
    inst_req = 1'b0;
    #1;
    chk("ilock_c4_daok", data_addr_ok, 1);
    chk("ilock_c4_addr", m_addr, 32'h0000_0400);
    tick();
    data_req = 1'b0; m_addr_ok = 1'b0;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    #1;
    chk("ilock_cnt", outst_cnt, 4);
    for (int i = 0; i < 4; i++) respond(32'hD000_0000 + i);
    chk("ilock_cnt_end", outst_cnt, 0);

    // In-order routing I, D, I
    issue(1'b0, 32'h0000_1000);
    issue(1'b1, 32'h0000_2000);
    issue(1'b0, 32'h0000_3000);
    respond(32'h0000_000A);
    respond(32'h0000_000B);
    respond(32'h0000_000C);
    chk("route_cnt", outst_cnt, 0);

    // Full: no new grant, and a same-cycle pop does not unblock combinationally
    for (int i = 0; i < 4; i++) issue(i[0], 32'h0000_4000 + 32'(i * 4));
    chk("full_cnt", outst_cnt, 4);
    inst_req = 1'b1; inst_addr = 32'h0000_5000; m_addr_ok = 1'b1;
    #1;
    chk("full_m_req", m_req, 0);
    chk("full_iaok", inst_addr_ok, 0);
    m_data_ok = 1'b1; m_rdata = 32'h0000_00F0;
    #1;
    chk("full_pop_m_req", m_req, 0);
    chk("full_pop_idok", inst_data_ok, 1);
    void'(exp_q.pop_front());
    tick();
    m_data_ok = 1'b0;
    #1;
    chk("full_after_m_req", m_req, 1);
    chk("full_after_iaok", inst_addr_ok, 1);
    chk("full_after_cnt", outst_cnt, 3);
    tick();
    inst_req = 1'b0; m_addr_ok = 1'b0;
    exp_q.push_back(1'b0);

    // Ten mixed transactions through the pointer wrap
    for (int i = 0; i < 10; i++) begin
      respond(32'h0000_00C0 + 32'(i));
      issue((i % 3) == 0, 32'h0000_6000 + 32'(i * 4));
    end
    for (int i = 0; i < 4; i++) respond(32'h0000_0E00 + 32'(i));
    chk("wrap_cnt", outst_cnt, 0);

    // Handshake and response in the same cycle at count 2
    issue(1'b1, 32'h0000_7000);
    issue(1'b0, 32'h0000_7004);
    data_req = 1'b1; data_addr = 32'h0000_7008; data_wdata = ~32'h0000_7008;
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h0000_0055;
    #1;
    chk("simul_daok", data_addr_ok, 1);
    chk("simul_ddok", data_data_ok, 1);
    chk("simul_idok", inst_data_ok, 0);
    tick();
    data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(1'b1);
    #1;
    chk("simul_cnt", outst_cnt, 2);
    respond(32'h0000_0056);
    respond(32'h0000_0057);

    // Stray response with nothing outstanding
    m_data_ok = 1'b1; m_rdata = 32'h0000_0099;
    #1;
    chk("err_idok", inst_data_ok, 0);
    chk("err_ddok", data_data_ok, 0);
    tick();
    m_data_ok = 1'b0;
    #1;
    chk("err_set", resp_err, 1);
    chk("err_cnt", outst_cnt, 0);
    repeat (3) tick();
    chk("err_sticky", resp_err, 1);
    issue(1'b0, 32'h0000_8000);
    respond(32'h0000_0077);
    chk("err_after_cnt", outst_cnt, 0);

`ifdef ARB_RR_EN
    // Round robin under continuous contention; last handshake was inst
    inst_req = 1'b1; data_req = 1'b1; m_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_daok", data_addr_ok, (i % 2) == 0);
      chk("rr_iaok", inst_addr_ok, (i % 2) == 1);
      exp_q.push_back((i % 2) == 0);
      tick();
    end
    inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) respond(32'h0000_0A00 + 32'(i));
    chk("rr_cnt", outst_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
